sprite_rect_drawer: RTL and testbench

- Parametrised successor to the per-enemy square drawers.
- Draws one SPR_W x SPR_H solid-colour sprite on the 160x120 VGA framebuffer, with optional trailing-column erase on the left or right.
- Emits one registered pixel per cycle with an explicit plot strobe.
- Sits between the game FSM (start/done handshake) and the VGA adapter (x, y, colour, plot); one instance per sprite, or one shared instance behind an arbiter.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/sprite_rect_drawer_if.sv | 37 +++
 rtl/coord_wrap.sv | 17 +
 rtl/sprite_rect_drawer.sv | 170 +++++++++++++++++
 tb/tb_sprite_rect_drawer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants, erase-mode encodings and drawer state type.
// Used by every sprite drawer and its testbenches.
package vga_pkg;

   localparam int VGA_SCREEN_W = 160;
   localparam int VGA_SCREEN_H = 120;
   localparam int VGA_XW       = 8;
   localparam int VGA_YW       = 7;
   localparam int VGA_CW       = 3;

   // 2'b00 and 2'b11 both mean "no erase column".
   localparam logic [1:0] ERASE_RIGHT = 2'b01;
   localparam logic [1:0] ERASE_LEFT  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_ERASE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   function automatic logic erase_enabled(input logic [1:0] mode);
      return (mode == ERASE_RIGHT) || (mode == ERASE_LEFT);
   endfunction

endpackage

// File: rtl/sprite_rect_drawer_if.sv
// Request/pixel bundle between the game FSM, a sprite drawer and the VGA adapter.
// The master drives the request side; the slave (the drawer) drives the pixel side.
interface sprite_rect_drawer_if #(
   parameter int XW = vga_pkg::VGA_XW,
   parameter int YW = vga_pkg::VGA_YW,
   parameter int CW = vga_pkg::VGA_CW
) ();

   // Handshake: start is a request sampled only while the drawer is idle (busy=0,
   // done=0); it is dropped, not queued, otherwise. Each accepted request yields a
   // run of cycles with plot=1 (each one a valid x/y/colour write, no back-pressure)
   // followed by a single-cycle done pulse. abort cancels with no done pulse.
   logic          abort;
   logic          start;
   logic [XW-1:0] sprite_x;
   logic [YW-1:0] sprite_y;
   logic [CW-1:0] sprite_colour;
   logic [CW-1:0] bg_colour;
   logic [1:0]    erase_mode;
   logic [XW-1:0] x_out;
   logic [YW-1:0] y_out;
   logic [CW-1:0] colour_out;
   logic          plot;
   logic          busy;
   logic          done;

   modport master (
      output abort, start, sprite_x, sprite_y, sprite_colour, bg_colour, erase_mode,
      input  x_out, y_out, colour_out, plot, busy, done
   );

   modport slave (
      input  abort, start, sprite_x, sprite_y, sprite_colour, bg_colour, erase_mode,
      output x_out, y_out, colour_out, plot, busy, done
   );

endinterface

// File: rtl/coord_wrap.sv
// (base + offset) mod N for base, offset < N, using one conditional subtraction.
module coord_wrap #(
   parameter int W = 8,
   parameter int N = 160
) (
   input  logic [W-1:0] base,
   input  logic [W-1:0] offset,
   output logic [W-1:0] sum
);

   logic [W:0] raw;

   // One extra bit so base+offset never overflows before the compare.
   assign raw = {1'b0, base} + {1'b0, offset};
   assign sum = (raw >= (W+1)'(N)) ? W'(raw - (W+1)'(N)) : raw[W-1:0];

endmodule

// File: rtl/sprite_rect_drawer.sv
// Draws one SPR_W x SPR_H solid sprite, column-major, with an optional trailing
// erase column, one registered pixel per cycle.
module sprite_rect_drawer import vga_pkg::*; #(
   parameter int SPR_W    = 4,
   parameter int SPR_H    = 4,
   parameter int SCREEN_W = VGA_SCREEN_W,
   parameter int SCREEN_H = VGA_SCREEN_H,
   parameter int XW       = VGA_XW,
   parameter int YW       = VGA_YW,
   parameter int CW       = VGA_CW
) (
   input  logic                 clk,
   input  logic                 reset,
   sprite_rect_drawer_if.slave  bus,
   output state_t               state_dbg
);

   localparam int CNTW = 4;

   state_t        state;
   logic [XW-1:0] lx;
   logic [YW-1:0] ly;
   logic [CW-1:0] lcolour;
   logic [CW-1:0] lbg;
   logic [1:0]    lmode;
   logic [CNTW-1:0] col;
   logic [CNTW-1:0] row;

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;
   logic [CW-1:0] colour_q;
   logic          plot_q;
   logic          busy_q;
   logic          done_q;

   logic [XW-1:0] in_x;
   logic [YW-1:0] in_y;
   logic          last_row;
   logic          fill_last;
   logic [CNTW-1:0] nrow;
   logic [CNTW-1:0] ncol;
   logic [XW-1:0] erase_off;
   logic [XW-1:0] x_off;
   logic [YW-1:0] y_off;
   logic [XW-1:0] x_wrap;
   logic [YW-1:0] y_wrap;

   assign in_x = (bus.sprite_x >= XW'(SCREEN_W)) ? bus.sprite_x - XW'(SCREEN_W) : bus.sprite_x;
   assign in_y = (bus.sprite_y >= YW'(SCREEN_H)) ? bus.sprite_y - YW'(SCREEN_H) : bus.sprite_y;

   assign last_row  = (row == CNTW'(SPR_H - 1));
   assign fill_last = last_row && (col == CNTW'(SPR_W - 1));
   assign nrow      = last_row ? '0 : row + CNTW'(1);
   assign ncol      = last_row ? col + CNTW'(1) : col;

   // Moving left leaves a stale column at lx+SPR_W; moving right at lx-1 == lx+N-1.
   assign erase_off = (lmode == ERASE_RIGHT) ? XW'(SPR_W) : XW'(SCREEN_W - 1);

   // Offsets select the pixel that the next edge registers.
   always_comb begin
      x_off = erase_off;
      y_off = YW'(nrow);
      if (state == ST_FILL) begin
         if (fill_last) y_off = '0;
         else           x_off = XW'(ncol);
      end
   end

   coord_wrap #(.W(XW), .N(SCREEN_W)) u_wrap_x (.base(lx), .offset(x_off), .sum(x_wrap));
   coord_wrap #(.W(YW), .N(SCREEN_H)) u_wrap_y (.base(ly), .offset(y_off), .sum(y_wrap));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         lx       <= '0;
         ly       <= '0;
         lcolour  <= '0;
         lbg      <= '0;
         lmode    <= '0;
         col      <= '0;
         row      <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (bus.abort) begin
         state  <= ST_IDLE;
         col    <= '0;
         row    <= '0;
         plot_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               plot_q <= 1'b0;
               done_q <= 1'b0;
               if (bus.start) begin
                  // Pixel (0,0) is emitted on the accepting edge itself.
                  lx       <= in_x;
                  ly       <= in_y;
                  lcolour  <= bus.sprite_colour;
                  lbg      <= bus.bg_colour;
                  lmode    <= bus.erase_mode;
                  col      <= '0;
                  row      <= '0;
                  x_q      <= in_x;
                  y_q      <= in_y;
                  colour_q <= bus.sprite_colour;
                  plot_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state    <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (fill_last) begin
                  col <= '0;
                  row <= '0;
                  if (erase_enabled(lmode)) begin
                     x_q      <= x_wrap;
                     y_q      <= y_wrap;
                     colour_q <= lbg;
                     state    <= ST_ERASE;
                  end else begin
                     plot_q <= 1'b0;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= ST_FINISH;
                  end
               end else begin
                  col      <= ncol;
                  row      <= nrow;
                  x_q      <= x_wrap;
                  y_q      <= y_wrap;
                  colour_q <= lcolour;
               end
            end
            ST_ERASE: begin
               if (last_row) begin
                  row    <= '0;
                  plot_q <= 1'b0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= ST_FINISH;
               end else begin
                  row <= nrow;
                  x_q <= x_wrap;
                  y_q <= y_wrap;
               end
            end
            ST_FINISH: begin
               done_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.x_out      = x_q;
   assign bus.y_out      = y_q;
   assign bus.colour_out = colour_q;
   assign bus.plot       = plot_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_sprite_rect_drawer.sv
// Bench for sprite_rect_drawer: default 4x4 instance plus a 6x3 instance, pixel
// scoreboards fed by a reference model, table-driven draws and corner sequences.
module tb_sprite_rect_drawer;
   import vga_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   logic reset2;

   sprite_rect_drawer_if bus ();
   sprite_rect_drawer_if bus2 ();
   state_t st;
   state_t st2;

   sprite_rect_drawer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (st)
   );

   sprite_rect_drawer #(.SPR_W(6), .SPR_H(3)) dut2 (
      .clk       (clk),
      .reset     (reset2),
      .bus       (bus2),
      .state_dbg (st2)
   );

   // ---------------- scoreboard ----------------
   localparam int W = 18;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp2_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   int cyc = 0, plot_cnt = 0, busy_cnt = 0, done_cnt = 0, first_cyc = 0, done_cyc = 0;
   int plot2_cnt = 0, done2_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: column-major fill then optional erase column.
   task automatic push_model(input int which, input int w, input int h,
                             input logic [7:0] x, input logic [6:0] y,
                             input logic [2:0] c, input logic [2:0] bg,
                             input logic [1:0] mode);
      int rx, ry, ex;
      logic [W-1:0] e;
      rx = (x >= 160) ? x - 160 : x;
      ry = (y >= 120) ? y - 120 : y;
      for (int ci = 0; ci < w; ci++) begin
         for (int r = 0; r < h; r++) begin
            e = {8'((rx + ci) % 160), 7'((ry + r) % 120), c};
            if (which == 0) exp_q.push_back(e); else exp2_q.push_back(e);
         end
      end
      if (mode == 2'b01 || mode == 2'b10) begin
         ex = (mode == 2'b01) ? (rx + w) % 160 : (rx + 159) % 160;
         for (int r = 0; r < h; r++) begin
            e = {8'(ex), 7'((ry + r) % 120), bg};
            if (which == 0) exp_q.push_back(e); else exp2_q.push_back(e);
         end
      end
   endtask

   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      cyc++;
      if (bus.plot) begin
         if (plot_cnt == 0) first_cyc = cyc;
         plot_cnt++;
         got = {bus.x_out, bus.y_out, bus.colour_out};
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_plot: got %h expected none", got);
         end else begin
            want = exp_q.pop_front();
            check("pixel", 32'(got), 32'(want));
         end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   always @(negedge clk) begin
      logic [W-1:0] got;
      logic [W-1:0] want;
      if (bus2.plot) begin
         plot2_cnt++;
         got = {bus2.x_out, bus2.y_out, bus2.colour_out};
         if (exp2_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_plot2: got %h expected none", got);
         end else begin
            want = exp2_q.pop_front();
            check("pixel2", 32'(got), 32'(want));
         end
      end
      if (bus2.done) done2_cnt++;
   end

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      plot_cnt  = 0;
      busy_cnt  = 0;
      done_cnt  = 0;
      first_cyc = 0;
      done_cyc  = 0;
   endtask

   task automatic launch(input int which, input logic [7:0] x, input logic [6:0] y,
                         input logic [2:0] c, input logic [2:0] bg, input logic [1:0] mode);
      push_model(which, (which == 0) ? 4 : 6, (which == 0) ? 4 : 3, x, y, c, bg, mode);
      @(posedge clk);
      #1;
      if (which == 0) begin
         bus.sprite_x = x; bus.sprite_y = y; bus.sprite_colour = c;
         bus.bg_colour = bg; bus.erase_mode = mode; bus.start = 1'b1;
      end else begin
         bus2.sprite_x = x; bus2.sprite_y = y; bus2.sprite_colour = c;
         bus2.bg_colour = bg; bus2.erase_mode = mode; bus2.start = 1'b1;
      end
      @(posedge clk);
      #1;
      // Inputs are scrambled after acceptance; only latched copies may matter.
      if (which == 0) begin
         bus.start = 1'b0;
         bus.sprite_x = 8'($urandom_range(0, 159));
         bus.sprite_y = 7'($urandom_range(0, 119));
         bus.sprite_colour = 3'($urandom_range(0, 7));
         bus.bg_colour = 3'($urandom_range(0, 7));
         bus.erase_mode = 2'($urandom_range(0, 3));
      end else begin
         bus2.start = 1'b0;
         bus2.sprite_x = 8'($urandom_range(0, 159));
         bus2.sprite_y = 7'($urandom_range(0, 119));
         bus2.erase_mode = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic wait_done(input int which, input string name, input int budget);
      for (int k = 0; k < budget; k++) begin
         if ((which == 0 && done_cnt != 0) || (which != 0 && done2_cnt != 0)) break;
         @(negedge clk);
         #1;
      end
      if ((which == 0 && done_cnt == 0) || (which != 0 && done2_cnt == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      logic [2:0] bg;
      logic [1:0] mode;
      int         plots;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{x: 8'd10,  y: 7'd20,  c: 3'b100, bg: 3'b001, mode: 2'b00, plots: 16};
      vecs[1] = '{x: 8'd158, y: 7'd118, c: 3'b010, bg: 3'b000, mode: 2'b01, plots: 20};
      vecs[2] = '{x: 8'd0,   y: 7'd50,  c: 3'b111, bg: 3'b011, mode: 2'b10, plots: 20};
      vecs[3] = '{x: 8'd200, y: 7'd125, c: 3'b001, bg: 3'b110, mode: 2'b11, plots: 16};
      vecs[4] = '{x: 8'd159, y: 7'd119, c: 3'b101, bg: 3'b010, mode: 2'b10, plots: 20};

      reset  = 1'b0;
      reset2 = 1'b0;
      bus.abort = 1'b0; bus.start = 1'b0; bus.sprite_x = '0; bus.sprite_y = '0;
      bus.sprite_colour = '0; bus.bg_colour = '0; bus.erase_mode = '0;
      bus2.abort = 1'b0; bus2.start = 1'b0; bus2.sprite_x = '0; bus2.sprite_y = '0;
      bus2.sprite_colour = '0; bus2.bg_colour = '0; bus2.erase_mode = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_x",      32'(bus.x_out), 0);
      check("rst_y",      32'(bus.y_out), 0);
      check("rst_colour", 32'(bus.colour_out), 0);
      check("rst_plot",   32'(bus.plot), 0);
      check("rst_busy",   32'(bus.busy), 0);
      check("rst_done",   32'(bus.done), 0);
      check("rst_state",  32'(st), 32'(ST_IDLE));
      reset  = 1'b1;
      reset2 = 1'b1;
      repeat (2) @(posedge clk);

      // Table-driven draws.
      for (int i = 0; i < 5; i++) begin
         clear_counts();
         launch(0, vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].bg, vecs[i].mode);
         wait_done(0, "vec_done", 60);
         repeat (2) @(posedge clk);
         #1;
         check("vec_plots",   32'(plot_cnt), 32'(vecs[i].plots));
         check("vec_busy",    32'(busy_cnt), 32'(vecs[i].plots));
         check("vec_dones",   32'(done_cnt), 1);
         check("vec_latency", 32'(done_cyc - first_cyc), 32'(vecs[i].plots));
         check("vec_queue",   32'(exp_q.size()), 0);
         check("vec_state",   32'(st), 32'(ST_IDLE));
      end

      // Abort on the fifth plot cycle.
      clear_counts();
      launch(0, 8'd30, 7'd40, 3'b110, 3'b000, 2'b01);
      for (int k = 0; k < 50 && plot_cnt < 5; k++) begin
         @(negedge clk);
         #1;
      end
      check("abort_reach5", 32'(plot_cnt), 5);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      check("abort_plot", 32'(bus.plot), 0);
      check("abort_busy", 32'(bus.busy), 0);
      repeat (25) @(posedge clk);
      #1;
      check("abort_plots", 32'(plot_cnt), 5);
      check("abort_nodone", 32'(done_cnt), 0);
      check("abort_left", 32'(exp_q.size()), 15);
      exp_q.delete();
      clear_counts();
      launch(0, 8'd30, 7'd40, 3'b110, 3'b000, 2'b00);
      wait_done(0, "after_abort", 60);
      repeat (2) @(posedge clk);
      #1;
      check("after_abort_plots", 32'(plot_cnt), 16);
      check("after_abort_dones", 32'(done_cnt), 1);

      // Start re-pulsed while busy with a different x.
      clear_counts();
      launch(0, 8'd70, 7'd60, 3'b011, 3'b000, 2'b00);
      repeat (3) @(posedge clk);
      #1;
      bus.sprite_x = 8'd90;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(0, "restart", 60);
      repeat (20) @(posedge clk);
      #1;
      check("restart_plots", 32'(plot_cnt), 16);
      check("restart_dones", 32'(done_cnt), 1);
      check("restart_queue", 32'(exp_q.size()), 0);

      // 6x3 instance: asynchronous reset mid-fill, then a wrapping draw.
      plot2_cnt = 0;
      done2_cnt = 0;
      launch(1, 8'd5, 7'd5, 3'b100, 3'b000, 2'b00);
      for (int k = 0; k < 50 && plot2_cnt < 7; k++) begin
         @(negedge clk);
         #1;
      end
      check("r2_reach7", 32'(plot2_cnt), 7);
      reset2 = 1'b0;
      #1;
      check("r2_x",      32'(bus2.x_out), 0);
      check("r2_y",      32'(bus2.y_out), 0);
      check("r2_colour", 32'(bus2.colour_out), 0);
      check("r2_plot",   32'(bus2.plot), 0);
      check("r2_busy",   32'(bus2.busy), 0);
      check("r2_state",  32'(st2), 32'(ST_IDLE));
      exp2_q.delete();
      @(posedge clk);
      #1;
      reset2 = 1'b1;
      plot2_cnt = 0;
      done2_cnt = 0;
      launch(1, 8'd157, 7'd118, 3'b011, 3'b101, 2'b01);
      wait_done(1, "r2_draw", 60);
      repeat (2) @(posedge clk);
      #1;
      check("r2_plots", 32'(plot2_cnt), 21);
      check("r2_dones", 32'(done2_cnt), 1);
      check("r2_queue", 32'(exp2_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
